// File: rtl/rs232_cmd_decoder.sv
// Host command decoder: turns 3-byte UART frames (flow, address, data) into register strobes
// and returns read data through the UART transmitter. Optional RS232_CMD_ACK_EN acks writes with 8'hAA.
module rs232_cmd_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 2500000,
  parameter int unsigned RD_LATENCY     = 1
) (
  input  logic       CLK_50MHZ,
  input  logic       RST,
  input  logic       RX_VALID,
  input  logic [7:0] RX_DATA,
  input  logic       TX_BUSY,
  output logic       TX_TRG,
  output logic [7:0] TX_DATA,
  output logic [7:0] REG_ADDR,
  output logic [7:0] REG_WDATA,
  output logic       REG_WE,
  output logic       REG_RE,
  input  logic [7:0] REG_RDATA,
  output logic       FRAME_ERR,
  output logic       RX_OVERRUN,
  output logic       BUSY
);

  localparam logic [21:0] TO_TERM  = 22'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  RDL_LAST = 3'(RD_LATENCY - 1);
`ifdef RS232_CMD_ACK_EN
  localparam logic [7:0]  ACK_BYTE = 8'hAA;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ADDR,
    S_WAIT_DATA,
    S_EXEC,
    S_READ_WAIT,
    S_TX_WAIT
  } state_e;

  state_e      state_q, state_d;
  logic        flow_rd_q, flow_rd_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  reg_addr_q, reg_addr_d;
  logic [7:0]  reg_wdata_q, reg_wdata_d;
  logic [7:0]  tx_pend_q, tx_pend_d;
  logic [7:0]  tx_last_q, tx_last_d;
  logic [21:0] cnt_q, cnt_d;
  logic [21:0] cnt_inc;
  logic [2:0]  rdl_q, rdl_d;

  logic in_frame;
  logic rx_take;
  logic to_hit;
  logic rd_last;
  logic tx_fire;

  assign in_frame = (state_q == S_WAIT_ADDR) || (state_q == S_WAIT_DATA);
  assign rx_take  = RX_VALID && ((state_q == S_IDLE) || in_frame);
  assign cnt_inc  = cnt_q + 22'd1;
  // A byte landing on the terminal count wins over the timeout.
  assign to_hit   = in_frame && !RX_VALID && (cnt_inc == TO_TERM);
  assign rd_last  = (state_q == S_READ_WAIT) && (rdl_q == RDL_LAST);
  assign tx_fire  = (state_q == S_TX_WAIT) && !TX_BUSY;

  always_ff @(posedge CLK_50MHZ or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (RX_VALID) state_d = S_WAIT_ADDR;
      end
      S_WAIT_ADDR: begin
        if (RX_VALID)    state_d = S_WAIT_DATA;
        else if (to_hit) state_d = S_IDLE;
      end
      S_WAIT_DATA: begin
        if (RX_VALID)    state_d = S_EXEC;
        else if (to_hit) state_d = S_IDLE;
      end
      S_EXEC: begin
        if (flow_rd_q) begin
          state_d = S_READ_WAIT;
        end else begin
`ifdef RS232_CMD_ACK_EN
          state_d = S_TX_WAIT;
`else
          state_d = S_IDLE;
`endif
        end
      end
      S_READ_WAIT: begin
        if (rd_last) state_d = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (!TX_BUSY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output registers REG_ADDR/REG_WDATA only change on the byte that completes a frame,
  // so they stay stable while the next frame is still being assembled.
  always_comb begin
    flow_rd_d   = flow_rd_q;
    addr_d      = addr_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    cnt_d       = cnt_q;
    rdl_d       = rdl_q;
    tx_pend_d   = tx_pend_q;
    tx_last_d   = tx_last_q;
    if ((state_q == S_IDLE) && RX_VALID) flow_rd_d = RX_DATA[0];
    if ((state_q == S_WAIT_ADDR) && RX_VALID) addr_d = RX_DATA;
    if ((state_q == S_WAIT_DATA) && RX_VALID) begin
      reg_addr_d  = addr_q;
      reg_wdata_d = RX_DATA;
    end
    if (rx_take)       cnt_d = '0;
    else if (in_frame) cnt_d = cnt_inc;
    if (state_q == S_EXEC)           rdl_d = '0;
    else if (state_q == S_READ_WAIT) rdl_d = rdl_q + 3'd1;
    if (rd_last) tx_pend_d = REG_RDATA;
`ifdef RS232_CMD_ACK_EN
    if ((state_q == S_EXEC) && !flow_rd_q) tx_pend_d = ACK_BYTE;
`endif
    if (tx_fire) tx_last_d = tx_pend_q;
  end

  always_ff @(posedge CLK_50MHZ or negedge RST) begin
    if (!RST) begin
      flow_rd_q   <= 1'b0;
      addr_q      <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      cnt_q       <= '0;
      rdl_q       <= '0;
      tx_pend_q   <= '0;
      tx_last_q   <= '0;
    end else begin
      flow_rd_q   <= flow_rd_d;
      addr_q      <= addr_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      cnt_q       <= cnt_d;
      rdl_q       <= rdl_d;
      tx_pend_q   <= tx_pend_d;
      tx_last_q   <= tx_last_d;
    end
  end

  // TX_DATA shows the pending byte while a trigger is outstanding, then holds what was sent.
  always_comb begin
    REG_ADDR   = reg_addr_q;
    REG_WDATA  = reg_wdata_q;
    REG_WE     = (state_q == S_EXEC) && !flow_rd_q;
    REG_RE     = (state_q == S_EXEC) && flow_rd_q;
    TX_TRG     = tx_fire;
    TX_DATA    = (state_q == S_TX_WAIT) ? tx_pend_q : tx_last_q;
    FRAME_ERR  = to_hit;
    RX_OVERRUN = RX_VALID && ((state_q == S_EXEC) || (state_q == S_READ_WAIT) ||
                              (state_q == S_TX_WAIT));
    BUSY       = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_rs232_cmd_decoder.sv
// Directed bench for rs232_cmd_decoder: one instance with the default timeout, one with a
// 16-cycle timeout, both driven by the same byte stream.
module tb_rs232_cmd_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_busy = 1'b0;
  logic [7:0] rdata = 8'h00;
  logic [7:0] rd_val = 8'h00;

  logic       trg0, we0, re0, ferr0, ovr0, busy0;
  logic [7:0] txd0, addr0, wd0;
  logic       trg1, we1, re1, ferr1, ovr1, busy1;
  logic [7:0] txd1, addr1, wd1;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  int we_cnt, we_cyc, re_cnt, re_cyc, trg_cnt, trg_cyc, ovr_cnt, ovr_cyc, ferr_cnt;
  logic [7:0] we_addr, we_wdata, re_addr, trg_data;
  int to_ferr_cnt, to_ferr_cyc, to_we_cnt;
  logic [7:0] to_we_addr, to_we_wdata;

  rs232_cmd_decoder #(.TIMEOUT_CYCLES(2500000), .RD_LATENCY(1)) dut (
    .CLK_50MHZ(clk), .RST(rst_n), .RX_VALID(rx_valid), .RX_DATA(rx_data),
    .TX_BUSY(tx_busy), .TX_TRG(trg0), .TX_DATA(txd0), .REG_ADDR(addr0),
    .REG_WDATA(wd0), .REG_WE(we0), .REG_RE(re0), .REG_RDATA(rdata),
    .FRAME_ERR(ferr0), .RX_OVERRUN(ovr0), .BUSY(busy0)
  );

  rs232_cmd_decoder #(.TIMEOUT_CYCLES(16), .RD_LATENCY(1)) dut_to (
    .CLK_50MHZ(clk), .RST(rst_n), .RX_VALID(rx_valid), .RX_DATA(rx_data),
    .TX_BUSY(tx_busy), .TX_TRG(trg1), .TX_DATA(txd1), .REG_ADDR(addr1),
    .REG_WDATA(wd1), .REG_WE(we1), .REG_RE(re1), .REG_RDATA(rdata),
    .FRAME_ERR(ferr1), .RX_OVERRUN(ovr1), .BUSY(busy1)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register bank model: data valid exactly one cycle after the read strobe, junk otherwise.
  always @(posedge clk) rdata <= re0 ? rd_val : 8'hE7;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] outs0();
    return {2'b00, trg0, txd0, addr0, wd0, we0, re0, ferr0, ovr0, busy0};
  endfunction

  function automatic logic [31:0] outs1();
    return {2'b00, trg1, txd1, addr1, wd1, we1, re1, ferr1, ovr1, busy1};
  endfunction

  always @(negedge clk) begin
    if (we0) begin
      we_cnt++; we_cyc = cyc; we_addr = addr0; we_wdata = wd0;
      check_vec("we_re_exclusive", {31'b0, re0}, 32'd0);
    end
    if (re0) begin
      re_cnt++; re_cyc = cyc; re_addr = addr0;
    end
    if (trg0) begin
      trg_cnt++; trg_cyc = cyc; trg_data = txd0;
      check_vec("trg_while_busy", {31'b0, tx_busy}, 32'd0);
    end
    if (trg1) check_vec("to_trg_while_busy", {31'b0, tx_busy}, 32'd0);
    if (ovr0) begin
      ovr_cnt++; ovr_cyc = cyc;
    end
    if (ferr0) ferr_cnt++;
    if (ferr1) begin
      to_ferr_cnt++; to_ferr_cyc = cyc;
    end
    if (we1) begin
      to_we_cnt++; to_we_addr = addr1; to_we_wdata = wd1;
    end
  end

  task automatic clear_ev();
    we_cnt = 0; we_cyc = 0; re_cnt = 0; re_cyc = 0; trg_cnt = 0; trg_cyc = 0;
    ovr_cnt = 0; ovr_cyc = 0; ferr_cnt = 0; to_ferr_cnt = 0; to_ferr_cyc = 0; to_we_cnt = 0;
    we_addr = 0; we_wdata = 0; re_addr = 0; trg_data = 0; to_we_addr = 0; to_we_wdata = 0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; rx_valid = 1'b0; tx_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_ev();
  endtask

  task automatic send_byte(input logic [7:0] b, output int c);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = b; c = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, w, r, a, ov, drop;
    clear_ev();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_vec("rst_outs", outs0(), 32'd0);
    check_vec("rst_outs_to", outs1(), 32'd0);
    #1 rst_n = 1'b1;

    // Write 00,18,03 with 200-cycle gaps
    apply_reset();
    send_byte(8'h00, c0);
    wait_cyc(c0 + 199);
    send_byte(8'h18, c1);
    wait_cyc(c1 + 199);
    send_byte(8'h03, w);
    wait_cyc(w + 6);
    check_vec("wr_we_cnt", we_cnt, 1);
    check_vec("wr_we_lat", we_cyc, w + 1);
    check_vec("wr_addr", we_addr, 8'h18);
    check_vec("wr_wdata", we_wdata, 8'h03);
    check_vec("wr_re_cnt", re_cnt, 0);
    check_vec("wr_ferr_cnt", ferr_cnt, 0);
`ifdef RS232_CMD_ACK_EN
    check_vec("wr_ack_cnt", trg_cnt, 1);
    check_vec("wr_ack_cyc", trg_cyc, w + 2);
    check_vec("wr_ack_data", trg_data, 8'hAA);
`else
    check_vec("wr_trg_cnt", trg_cnt, 0);
`endif

    // Read 01,19,FF returning 0x0C
    apply_reset();
    rd_val = 8'h0C;
    send_byte(8'h01, c0);
    send_byte(8'h19, c1);
    send_byte(8'hFF, r);
    wait_cyc(r + 8);
    check_vec("rd_re_cnt", re_cnt, 1);
    check_vec("rd_re_lat", re_cyc, r + 1);
    check_vec("rd_addr", re_addr, 8'h19);
    check_vec("rd_trg_cnt", trg_cnt, 1);
    check_vec("rd_trg_lat", trg_cyc, r + 3);
    check_vec("rd_trg_data", trg_data, 8'h0C);
    check_vec("rd_we_cnt", we_cnt, 0);
    check_vec("rd_ovr_cnt", ovr_cnt, 0);

    // Read 01,1A,FF with TX busy for 100 cycles, overrun bytes, then a fresh frame
    apply_reset();
    rd_val = 8'h3C;
    tx_busy = 1'b1;
    send_byte(8'h01, c0);
    send_byte(8'h1A, c1);
    send_byte(8'hFF, r);
    wait_cyc(r + 19);
    send_byte(8'h55, ov);
    wait_cyc(r + 100);
    check_vec("busy_hold_state", {31'b0, busy0}, 32'd1);
    check_vec("busy_hold_trg", trg_cnt, 0);
    check_vec("ovr_first_cnt", ovr_cnt, 1);
    check_vec("ovr_first_cyc", ovr_cyc, ov);
    @(posedge clk); #1;
    tx_busy = 1'b0; rx_valid = 1'b1; rx_data = 8'h01; drop = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    wait_cyc(r + 106);
    check_vec("busy_trg_cnt", trg_cnt, 1);
    check_vec("busy_trg_cyc", trg_cyc, drop);
    check_vec("busy_trg_data", trg_data, 8'h3C);
    check_vec("ovr_last_cnt", ovr_cnt, 2);
    check_vec("ovr_last_cyc", ovr_cyc, drop);
    check_vec("busy_idle", {31'b0, busy0}, 32'd0);
    clear_ev();
    send_byte(8'h00, c0);
    send_byte(8'h1B, c1);
    send_byte(8'h77, w);
    wait_cyc(w + 4);
    check_vec("fresh_we_cnt", we_cnt, 1);
    check_vec("fresh_addr", we_addr, 8'h1B);
    check_vec("fresh_wdata", we_wdata, 8'h77);

    // Timeout (16-cycle instance), then a normal write
    apply_reset();
    send_byte(8'h00, c0);
    send_byte(8'h18, a);
    wait_cyc(a + 20);
    check_vec("to_ferr_cnt", to_ferr_cnt, 1);
    check_vec("to_ferr_cyc", to_ferr_cyc, a + 15);
    check_vec("to_idle", {31'b0, busy1}, 32'd0);
    send_byte(8'h00, c0);
    send_byte(8'h19, c1);
    send_byte(8'h0C, w);
    wait_cyc(w + 4);
    check_vec("to_we_cnt", to_we_cnt, 1);
    check_vec("to_we_addr", to_we_addr, 8'h19);
    check_vec("to_we_wdata", to_we_wdata, 8'h0C);
    check_vec("to_ferr_after", to_ferr_cnt, 1);

    // Byte on the terminal-count cycle is accepted, timeout suppressed
    apply_reset();
    send_byte(8'h00, c0);
    send_byte(8'h18, a);
    wait_cyc(a + 14);
    send_byte(8'h42, w);
    wait_cyc(w + 4);
    check_vec("term_byte_cyc", w, a + 15);
    check_vec("term_ferr_cnt", to_ferr_cnt, 0);
    check_vec("term_we_cnt", to_we_cnt, 1);
    check_vec("term_we_wdata", to_we_wdata, 8'h42);

    // Asynchronous reset mid-frame
    apply_reset();
    send_byte(8'h00, c0);
    send_byte(8'h18, c1);
    send_byte(8'h03, w);
    wait_cyc(w + 3);
    clear_ev();
    send_byte(8'h00, c0);
    send_byte(8'h18, c1);
    check_vec("pre_rst_addr_hold", addr0, 8'h18);
    check_vec("pre_rst_busy", {31'b0, busy0}, 32'd1);
    #2 rst_n = 1'b0;
    #2;
    check_vec("async_rst_outs", outs0(), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_vec("rst_hold_outs", outs0(), 32'd0);
    rst_n = 1'b1;
    wait_cyc(cyc + 5);
    check_vec("post_rst_we_cnt", we_cnt, 0);
    check_vec("post_rst_busy", {31'b0, busy0}, 32'd0);
    send_byte(8'h00, c0);
    send_byte(8'h18, c1);
    send_byte(8'h03, w);
    wait_cyc(w + 4);
    check_vec("post_rst_wr_cnt", we_cnt, 1);
    check_vec("post_rst_wr_lat", we_cyc, w + 1);
    check_vec("post_rst_wr_addr", we_addr, 8'h18);
    check_vec("post_rst_wr_wdata", we_wdata, 8'h03);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
